// File: rtl/miner_nonce_checker.sv
// Job controller / result checker: clears the nonce counter, issues nonces with an
// in-flight cap, checks returned hashes against the target and reports to the host.
// Optional MINER_HIT_COUNT_EN adds a saturating hit_count output.
module miner_nonce_checker #(
   parameter int unsigned HASH_W       = 256,
   parameter int unsigned NONCE_W      = 32,
   parameter int unsigned MAX_INFLIGHT = 64
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic               abort,
   input  logic [HASH_W-1:0]  target,
   output logic               clear,
   output logic               count_enable,
   input  logic               nonce_flag,
   input  logic               hash_valid,
   input  logic [HASH_W-1:0]  hash,
   input  logic [NONCE_W-1:0] hash_nonce,
   output logic               busy,
   output logic               result_valid,
   input  logic               result_ack,
   output logic               found,
`ifdef MINER_HIT_COUNT_EN
   output logic [NONCE_W-1:0] golden_nonce,
   output logic [15:0]        hit_count
`else
   output logic [NONCE_W-1:0] golden_nonce
`endif
);

   localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      RUN    = 3'd2,
      DRAIN  = 3'd3,
      REPORT = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [INF_W-1:0]     inflight_q, inflight_d;
   logic [HASH_W-1:0]    target_q, target_d;
   logic                 found_q, found_d;
   logic [NONCE_W-1:0]   golden_q, golden_d;
   logic                 clear_q, clear_d;
   logic                 count_enable_q, count_enable_d;
   logic                 busy_q, busy_d;
   logic                 result_valid_q, result_valid_d;
   logic                 active_c;
   logic                 hit_c;
   logic                 inc_c;
   logic                 dec_c;
`ifdef MINER_HIT_COUNT_EN
   logic [15:0]          hit_count_q, hit_count_d;
`endif

   // Next-state, in-flight tracking, hit capture and registered output values
   always_comb begin
      state_d        = state_q;
      inflight_d     = inflight_q;
      target_d       = target_q;
      found_d        = found_q;
      golden_d       = golden_q;
`ifdef MINER_HIT_COUNT_EN
      hit_count_d    = hit_count_q;
`endif
      active_c       = (state_q == RUN) || (state_q == DRAIN);
      hit_c          = active_c && hash_valid && (hash < target_q);
      inc_c          = count_enable_q;
      dec_c          = active_c && hash_valid && (inflight_q != '0);

      unique case ({inc_c, dec_c})
         2'b10:   inflight_d = inflight_q + INF_W'(1);
         2'b01:   inflight_d = inflight_q - INF_W'(1);
         default: inflight_d = inflight_q;
      endcase

      if (hit_c && !found_q) begin
         found_d  = 1'b1;
         golden_d = hash_nonce;
      end
`ifdef MINER_HIT_COUNT_EN
      if (hit_c && (hit_count_q != 16'hFFFF)) begin
         hit_count_d = hit_count_q + 16'd1;
      end
`endif

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = CLEAR;
               target_d = target;
               found_d  = 1'b0;
               golden_d = '0;
`ifdef MINER_HIT_COUNT_EN
               hit_count_d = 16'd0;
`endif
            end
         end
         CLEAR:  state_d = RUN;
         RUN: begin
            if (hit_c || nonce_flag) state_d = DRAIN;
         end
         // Leave once the count reaching zero this cycle is certain
         DRAIN: begin
            if (inflight_d == '0) state_d = REPORT;
         end
         REPORT: begin
            if (result_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d    = IDLE;
         inflight_d = '0;
`ifdef MINER_HIT_COUNT_EN
         hit_count_d = 16'd0;
`endif
      end

      clear_d        = abort || (state_d == CLEAR);
      count_enable_d = (state_d == RUN) && (inflight_d < INF_W'(MAX_INFLIGHT));
      busy_d         = (state_d != IDLE);
      result_valid_d = (state_d == REPORT);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= IDLE;
         inflight_q     <= '0;
         target_q       <= '0;
         found_q        <= 1'b0;
         golden_q       <= '0;
         clear_q        <= 1'b0;
         count_enable_q <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
`ifdef MINER_HIT_COUNT_EN
         hit_count_q    <= 16'd0;
`endif
      end else begin
         state_q        <= state_d;
         inflight_q     <= inflight_d;
         target_q       <= target_d;
         found_q        <= found_d;
         golden_q       <= golden_d;
         clear_q        <= clear_d;
         count_enable_q <= count_enable_d;
         busy_q         <= busy_d;
         result_valid_q <= result_valid_d;
`ifdef MINER_HIT_COUNT_EN
         hit_count_q    <= hit_count_d;
`endif
      end
   end

   assign clear        = clear_q;
   assign count_enable = count_enable_q;
   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign found        = found_q;
   assign golden_nonce = golden_q;
`ifdef MINER_HIT_COUNT_EN
   assign hit_count    = hit_count_q;
`endif

endmodule

// File: tb/tb_miner_nonce_checker.sv
// Bench for miner_nonce_checker: acts as nonce counter and in-order hash pipeline,
// compares every cycle against a queue-based job model.
module tb_miner_nonce_checker;

   localparam int unsigned HASH_W  = 256;
   localparam int unsigned NONCE_W = 32;
   localparam int unsigned MAXI    = 4;

   localparam int P_IDLE = 0, P_CLEAR = 1, P_RUN = 2, P_DRAIN = 3, P_REPORT = 4;

   logic clk, n_rst, start, abort, nonce_flag, hash_valid, result_ack;
   logic [HASH_W-1:0]  target, hash;
   logic [NONCE_W-1:0] hash_nonce, golden_nonce;
   logic clear, count_enable, busy, result_valid, found;
`ifdef MINER_HIT_COUNT_EN
   logic [15:0] hit_count;
`endif

   miner_nonce_checker #(.HASH_W(HASH_W), .NONCE_W(NONCE_W), .MAX_INFLIGHT(MAXI)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .target(target),
      .clear(clear), .count_enable(count_enable), .nonce_flag(nonce_flag),
      .hash_valid(hash_valid), .hash(hash), .hash_nonce(hash_nonce), .busy(busy),
      .result_valid(result_valid), .result_ack(result_ack), .found(found),
`ifdef MINER_HIT_COUNT_EN
      .hit_count(hit_count),
`endif
      .golden_nonce(golden_nonce));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_err    = 0;

   // job model
   int                 m_phase = P_IDLE;
   logic [HASH_W-1:0]  m_tgt = '0;
   logic               m_found = 1'b0;
   logic [NONCE_W-1:0] m_golden = '0;
   int                 m_hc = 0;
   bit                 m_abort_prev = 1'b0;
   logic [NONCE_W-1:0] q[$];
   logic [NONCE_W-1:0] nonce_ctr = '0;
   logic [NONCE_W-1:0] nonce_base = '0;
   logic [NONCE_W-1:0] hit_list[$];

   // stimulus knobs
   bit k_start, k_abort, k_flag, k_ack, junk_hv;
   int ret_pct = 0;
   logic [HASH_W-1:0] k_target = '0;

   task automatic chk(input string tag, input logic [HASH_W-1:0] obs, input logic [HASH_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_phase(input string tag, input int want);
      n_checks++;
      assert (m_phase == want) else begin
         n_err++;
         $error("FAIL %s wait budget expired observed_phase=%0d expected_phase=%0d", tag, m_phase, want);
      end
   endtask

   function automatic logic [HASH_W-1:0] rand256();
      logic [HASH_W-1:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic bit in_list(input logic [NONCE_W-1:0] n);
      foreach (hit_list[i]) if (hit_list[i] == n) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [HASH_W-1:0] make_hash(input bit want_hit);
      logic [HASH_W-1:0] r;
      int sel;
      r   = rand256();
      sel = $urandom_range(0, 2);
      if (want_hit && m_tgt != '0) begin
         if (sel == 0)      return '0;
         else if (sel == 1) return m_tgt - 1'b1;
         else               return r & (m_tgt >> 1);
      end
      if (sel == 0)      return m_tgt;
      else if (sel == 1) return '1;
      else               return m_tgt | r;
   endfunction

   // one clock: check outputs of this cycle, drive inputs, advance the model
   task automatic tick();
      bit exp_ce, hv, hit;
      logic [HASH_W-1:0]  h;
      logic [NONCE_W-1:0] hn;
      @(negedge clk);
      exp_ce = (m_phase == P_RUN) && (q.size() < MAXI);
      chk("busy", {255'd0, busy}, {255'd0, m_phase != P_IDLE});
      chk("clear", {255'd0, clear}, {255'd0, (m_phase == P_CLEAR) || m_abort_prev});
      chk("count_enable", {255'd0, count_enable}, {255'd0, exp_ce});
      chk("result_valid", {255'd0, result_valid}, {255'd0, m_phase == P_REPORT});
      chk("found", {255'd0, found}, {255'd0, m_found});
      chk("golden_nonce", HASH_W'(golden_nonce), HASH_W'(m_golden));
`ifdef MINER_HIT_COUNT_EN
      chk("hit_count", HASH_W'(hit_count), HASH_W'(m_hc));
`endif
      hv = 1'b0;
      h  = rand256();
      hn = $urandom();
      if ((m_phase == P_RUN || m_phase == P_DRAIN) && q.size() > 0 &&
          $urandom_range(0, 99) < ret_pct) begin
         hv = 1'b1;
         hn = q.pop_front();
         h  = make_hash(in_list(hn));
      end else if (junk_hv && !(m_phase == P_RUN || m_phase == P_DRAIN)) begin
         hv = 1'b1;
         h  = '0;
      end
      start = k_start; abort = k_abort; nonce_flag = k_flag; result_ack = k_ack;
      target = k_target; hash_valid = hv; hash = h; hash_nonce = hn;

      hit = hv && (m_phase == P_RUN || m_phase == P_DRAIN) && (h < m_tgt);
      if (hit) begin
         if (m_hc < 16'hFFFF) m_hc++;
         if (!m_found) begin m_found = 1'b1; m_golden = hn; end
      end
      if (exp_ce) begin q.push_back(nonce_ctr); nonce_ctr++; end
      if (k_abort) begin
         m_phase = P_IDLE; q.delete(); m_hc = 0; m_abort_prev = 1'b1;
      end else begin
         m_abort_prev = 1'b0;
         case (m_phase)
            P_IDLE: if (k_start) begin
               m_phase = P_CLEAR; m_tgt = k_target; m_found = 1'b0; m_golden = '0;
               m_hc = 0; nonce_ctr = nonce_base;
            end
            P_CLEAR:  m_phase = P_RUN;
            P_RUN:    if (hit || k_flag) m_phase = P_DRAIN;
            P_DRAIN:  if (q.size() == 0) m_phase = P_REPORT;
            P_REPORT: if (k_ack) m_phase = P_IDLE;
            default:  m_phase = P_IDLE;
         endcase
      end
      k_start = 1'b0; k_abort = 1'b0; k_flag = 1'b0; k_ack = 1'b0;
   endtask

   task automatic wait_phase(input int ph, input int budget, input string tag);
      int k = 0;
      while (m_phase != ph && k < budget) begin tick(); k++; end
      chk_phase(tag, ph);
   endtask

   task automatic wait_q(input int n, input int budget, input string tag);
      int k = 0;
      while (q.size() < n && k < budget) begin tick(); k++; end
      n_checks++;
      assert (q.size() >= n) else begin
         n_err++;
         $error("FAIL %s observed_inflight=%0d expected_inflight=%0d", tag, q.size(), n);
      end
   endtask

   task automatic finish_job(input string tag);
      ret_pct = 100;
      wait_phase(P_REPORT, 200, tag);
      tick();
      k_ack = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      int n;
      logic [NONCE_W-1:0] flag_off;
      n_rst = 1'b0; start = 0; abort = 0; nonce_flag = 0; hash_valid = 0; result_ack = 0;
      target = '0; hash = '0; hash_nonce = '0;
      k_start = 0; k_abort = 0; k_flag = 0; k_ack = 0; junk_hv = 0;
      #12;
      chk("rst_busy", {255'd0, busy}, '0);
      chk("rst_clear", {255'd0, clear}, '0);
      chk("rst_ce", {255'd0, count_enable}, '0);
      chk("rst_rv", {255'd0, result_valid}, '0);
      chk("rst_found", {255'd0, found}, '0);
      chk("rst_golden", HASH_W'(golden_nonce), '0);
      n_rst = 1'b1;
      tick();

      // hit on the 5th result
      k_target = {HASH_W{1'b1}} >> 8; hit_list = '{32'h4}; nonce_base = '0; ret_pct = 60;
      k_start = 1'b1;
      tick();
      wait_phase(P_REPORT, 200, "s1_report");
      chk("s1_found", {255'd0, found}, 256'd1);
      chk("s1_golden", HASH_W'(golden_nonce), 256'h4);
      k_ack = 1'b1; tick(); tick();

      // target zero, nonce_flag with results in flight
      k_target = '0; hit_list.delete(); ret_pct = 0; k_start = 1'b1;
      tick();
      wait_q(2, 20, "s2_fill");
      k_flag = 1'b1;
      tick();
      tick();
      chk("s2_ce_drop", {255'd0, count_enable}, '0);
      ret_pct = 40;
      wait_phase(P_REPORT, 200, "s2_report");
      chk("s2_found", {255'd0, found}, '0);
      k_ack = 1'b1; tick(); tick();

      // hit and nonce_flag together on the all-ones nonce
      k_target = {HASH_W{1'b1}} >> 8; hit_list = '{32'hFFFFFFFF}; nonce_base = 32'hFFFFFFFD;
      ret_pct = 0; k_start = 1'b1;
      tick();
      wait_q(3, 20, "s3_fill");
      ret_pct = 100;
      n = 0;
      while (q.size() > 0 && q[0] != 32'hFFFFFFFF && n < 10) begin tick(); n++; end
      k_flag = 1'b1;
      tick();
      finish_job("s3_report");
      chk("s3_found", {255'd0, found}, 256'd1);
      chk("s3_golden", HASH_W'(golden_nonce), 256'hFFFFFFFF);

      // in-flight cap stall and single-slot release
      k_target = '0; hit_list.delete(); nonce_base = '0; ret_pct = 0; k_start = 1'b1;
      tick();
      n = 0;
      repeat (12) begin tick(); n += int'(count_enable); end
      chk("s4_ce_cycles", HASH_W'(n), 256'd4);
      ret_pct = 100; tick(); ret_pct = 0;
      n = 0;
      repeat (6) begin tick(); n += int'(count_enable); end
      chk("s4_ce_release", HASH_W'(n), 256'd1);
      k_flag = 1'b1; tick();
      finish_job("s4_report");

      // abort in DRAIN with two in flight, then a normal job
      junk_hv = 1'b1;
      k_target = '0; ret_pct = 0; k_start = 1'b1;
      tick();
      wait_q(4, 20, "s5_fill");
      k_flag = 1'b1; tick();
      ret_pct = 100; tick(); tick(); ret_pct = 0;
      k_abort = 1'b1; tick();
      tick();
      chk("s5_abort_busy", {255'd0, busy}, '0);
      chk("s5_abort_clear", {255'd0, clear}, 256'd1);
      repeat (5) tick();
      k_target = {HASH_W{1'b1}} >> 4; hit_list = '{32'h7}; ret_pct = 50; k_start = 1'b1;
      tick();
      finish_job("s5_report");
      chk("s5_golden", HASH_W'(golden_nonce), 256'h7);

      // three hits: one in RUN, two in DRAIN
      k_target = {HASH_W{1'b1}} >> 8; hit_list = '{32'h1, 32'h2, 32'h3}; ret_pct = 0;
      k_start = 1'b1;
      tick();
      wait_q(4, 20, "s6_fill");
      ret_pct = 100;
      wait_phase(P_REPORT, 50, "s6_report");
      chk("s6_golden", HASH_W'(golden_nonce), 256'h1);
`ifdef MINER_HIT_COUNT_EN
      chk("s6_hit_count", HASH_W'(hit_count), 256'd3);
`endif
      repeat (3) tick();
      k_ack = 1'b1; tick(); tick();

      // randomized jobs with ignored start/ack noise
      for (int job = 0; job < 6; job++) begin
         int cyc;
         bit flagged;
         k_target = rand256() >> $urandom_range(0, 12);
         nonce_base = $urandom();
         hit_list.delete();
         if ($urandom_range(0, 1) == 1) hit_list.push_back(nonce_base + 32'($urandom_range(3, 40)));
         if ($urandom_range(0, 1) == 1) hit_list.push_back(nonce_base + 32'($urandom_range(3, 40)));
         ret_pct = $urandom_range(20, 90);
         k_start = 1'b1;
         tick();
         cyc = 0; flagged = 1'b0;
         while (m_phase != P_REPORT && cyc < 400) begin
            flag_off = nonce_ctr - nonce_base;
            if (m_phase == P_RUN && !flagged && flag_off >= 32'd30) begin
               k_flag = 1'b1; flagged = 1'b1;
            end
            if (m_phase != P_IDLE && $urandom_range(0, 9) == 0) k_start = 1'b1;
            if ($urandom_range(0, 9) == 0) k_ack = 1'b1;
            tick();
            cyc++;
         end
         chk_phase("rand_report", P_REPORT);
         repeat ($urandom_range(0, 3)) tick();
         k_ack = 1'b1; tick(); tick();
      end

      // asynchronous reset in the middle of a job
      k_target = {HASH_W{1'b1}}; hit_list = '{32'h2}; nonce_base = '0; ret_pct = 70;
      k_start = 1'b1;
      tick();
      repeat (8) tick();
      #2 n_rst = 1'b0;
      #1;
      chk("mid_rst_busy", {255'd0, busy}, '0);
      chk("mid_rst_ce", {255'd0, count_enable}, '0);
      chk("mid_rst_rv", {255'd0, result_valid}, '0);
      chk("mid_rst_found", {255'd0, found}, '0);
      chk("mid_rst_golden", HASH_W'(golden_nonce), '0);
`ifdef MINER_HIT_COUNT_EN
      chk("mid_rst_hit_count", HASH_W'(hit_count), '0);
`endif
      start = 0; abort = 0; nonce_flag = 0; hash_valid = 0; result_ack = 0;
      m_phase = P_IDLE; q.delete(); m_found = 1'b0; m_golden = '0; m_hc = 0; m_abort_prev = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/miner_nonce_checker.md
# miner_nonce_checker

Job controller and result checker on the consuming side of the miner nonce counter. Starts a job by clearing the counter, then drives `count_enable` to issue one nonce per cycle into the hash pipeline. It checks each returned hash against the job target and stops on the first hit or when the nonce space is exhausted. It drains all in-flight results, then reports a golden nonce or an exhausted status to the host over a valid/ack handshake.

## Interface
- `HASH_W`, 256, hash and target width
- `NONCE_W`, 32, nonce width
- `MAX_INFLIGHT`, 64, maximum nonces issued but not yet returned by the hash pipeline

- `clk` in 1: system clock
- `n_rst` in 1: asynchronous active-low reset
- `start` in 1: single-cycle job start; sampled only in IDLE
- `abort` in 1: cancel the job from any state
- `target` in HASH_W: job target; latched on accepted `start`
- `clear` out 1: counter clear
- `count_enable` out 1: counter advance
- `nonce_flag` in 1: counter has issued the last nonce
- `hash_valid` in 1: pipeline result valid; always accepted
- `hash` in HASH_W: result hash
- `hash_nonce` in NONCE_W: nonce tagged to `hash`
- `busy` out 1: high in every state except IDLE
- `result_valid` out 1: report valid; held until acknowledged
- `result_ack` in 1: host acknowledge
- `found` out 1: report is a hit (0 means exhausted)
- `golden_nonce` out NONCE_W: winning nonce

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, REPORT.
- IDLE + `start` → CLEAR. Latch `target`, zero the hit register.
- CLEAR: `clear`=1 for exactly one cycle, then → RUN.
- RUN: `count_enable`=1 while `inflight` < MAX_INFLIGHT, otherwise 0 (stall).
- `inflight` update each cycle: +1 on `count_enable`, −1 on `hash_valid`, both in the same cycle means no change. Width is clog2(MAX_INFLIGHT+1). Never wraps.
- Hit test: unsigned `hash` < `target`. `hash` == `target` is a miss.
- First hit in RUN or DRAIN latches `found`=1 and `golden_nonce`=`hash_nonce`. Later hits are ignored.
- RUN → DRAIN on a hit or on `nonce_flag`. A hit and `nonce_flag` in the same cycle → DRAIN with the hit recorded.
- DRAIN: `count_enable`=0. Hits are still tested. → REPORT when `inflight`==0 and no `hash_valid` is present.
- REPORT: `result_valid`=1 until `result_ack`, then → IDLE. `found` and `golden_nonce` are stable for the whole of REPORT.
- `abort` takes priority over all transitions. It forces → IDLE, pulses `clear` one cycle, zeroes `inflight`, and produces no report.
- `start` outside IDLE is ignored. `result_ack` outside REPORT is ignored.
- `hash_valid` in IDLE, CLEAR or REPORT is ignored and does not underflow `inflight`.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `clear`=0, `count_enable`=0, `busy`=0, `result_valid`=0, `found`=0, `golden_nonce`=0, `inflight`=0.
- `start` in cycle T: `clear`=1 in T+1, `count_enable`=1 from T+2.
- Hit on `hash_valid` at T: `count_enable`=0 from T+1. `found`/`golden_nonce` are visible from T+1.
- `nonce_flag` at T: `count_enable`=0 from T+1.
- Last in-flight result at T: `result_valid`=1 at T+1.
- `result_ack` at T: `result_valid`=0 and `busy`=0 at T+1. A new `start` is accepted at T+1.
- `abort` at T: `clear`=1 and `busy`=0 at T+1.
- Reset mid-job: all state and outputs take their reset values immediately (asynchronously).

## Configuration
- `MINER_HIT_COUNT_EN` defined: adds output `hit_count` [15:0]. It counts every hit accepted in RUN or DRAIN, including hits after the first. It saturates at 16'hFFFF, zeroes on accepted `start` and on `abort`, holds through REPORT, and resets to 0.
- Undefined: no `hit_count` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset, then `start` with `target`=all-ones >> 8; hit on the 5th result, `hash_nonce`=32'h4 → `found`=1, `golden_nonce`=32'h4, `result_valid` only after all in-flight results have returned.
- `target`=0 (no hit possible); `nonce_flag` pulsed with 3 results in flight → `count_enable` drops the next cycle, `result_valid` comes 1 cycle after the 3rd result, `found`=0.
- Hit and `nonce_flag` in the same cycle, `hash_nonce`=32'hFFFFFFFF → `found`=1, `golden_nonce`=32'hFFFFFFFF.
- MAX_INFLIGHT=4 with `hash_valid` held low → `count_enable` high for exactly 4 cycles, then stalls; one `hash_valid` re-enables it for 1 cycle.
- `abort` in DRAIN with 2 results in flight → `busy`=0 and `clear`=1 the next cycle, no `result_valid`; a following `start` runs a normal job.
- With `MINER_HIT_COUNT_EN`: 3 hits (1 in RUN, 2 in DRAIN) → `hit_count`=3; `golden_nonce` equals the first hit's nonce.
